// File: rtl/svc_rv_hazard_ctrl_pkg.sv
// Register-file constants shared by the hazard control slice.
package svc_rv_hazard_ctrl_pkg;
    localparam int unsigned REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_X0 = '0;
endpackage

// File: rtl/svc_rv_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module svc_rv_hazard_detect
    import svc_rv_hazard_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 uses_rs1_id,
    input  logic                 uses_rs2_id,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 reg_write_ex,
    input  logic                 is_load_ex,
    output logic                 load_use
);
    // Writes to x0 are discarded, so they can never create a dependency.
    assign load_use = is_load_ex & reg_write_ex & (rd_ex != REG_X0) &
                      ((uses_rs1_id & (rs1_id == rd_ex)) |
                       (uses_rs2_id & (rs2_id == rd_ex)));
endmodule

// File: rtl/svc_rv_hazard_ctrl.sv
// Pipeline hazard control: redirect flushes, load-use bubbles and multi-cycle
// op stalls with a timeout abort, plus stall/flush performance counters.
module svc_rv_hazard_ctrl
    import svc_rv_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs1_id,
    input  logic [REG_IDX_W-1:0] rs2_id,
    input  logic                 uses_rs1_id,
    input  logic                 uses_rs2_id,
    input  logic [REG_IDX_W-1:0] rd_ex,
    input  logic                 reg_write_ex,
    input  logic                 is_load_ex,
    input  logic                 is_mc_ex,
    input  logic                 mc_done,
    input  logic                 redirect_ex,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 flush_id,
    output logic                 flush_ex,
    output logic                 mc_start,
    output logic                 mc_busy,
    output logic                 mc_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);
    localparam logic ST_RUN     = 1'b0;
    localparam logic ST_MC_WAIT = 1'b1;

    localparam int unsigned WAIT_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MC_TIMEOUT - 1);

    logic              state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
    logic              load_use;

    svc_rv_hazard_detect u_detect (
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .uses_rs1_id  (uses_rs1_id),
        .uses_rs2_id  (uses_rs2_id),
        .rd_ex        (rd_ex),
        .reg_write_ex (reg_write_ex),
        .is_load_ex   (is_load_ex),
        .load_use     (load_use)
    );

    // Controls are held low while in reset so a pending op is never restarted.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        mc_start  = 1'b0;
        mc_busy   = 1'b0;
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        if (rst_n) begin
            case (state_q)
                ST_RUN: begin
                    if (redirect_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (is_mc_ex) begin
                        mc_start = 1'b1;
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                        state_d  = ST_MC_WAIT;
                        wait_d   = '0;
                    end else if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    mc_busy = 1'b1;
                    if (mc_done) begin
                        state_d = ST_RUN;
                    end else if (wait_q == WAIT_LAST) begin
                        // This wait cycle brings the count to MC_TIMEOUT: abort.
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        stall_ex = 1'b1;
                        wait_d   = wait_q + WAIT_W'(1);
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_q      <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_if);
            flush_cnt_q <= flush_cnt_q + CNT_W'(flush_ex);
        end
    end

    assign mc_timeout = timeout_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule
